// File: rtl/rs_alu_station_pkg.sv
// rs_alu_station_pkg: shared constants, opcode map and entry type for the ALU reservation station
package rs_alu_station_pkg;
  localparam int ROB_NONE = 0;
  localparam int OP_NOP = 0, OP_LUI = 1, OP_AUIPC = 2, OP_JAL = 3, OP_JALR = 4;
  localparam int OP_BEQ = 5, OP_BNE = 6, OP_BLT = 7, OP_BGE = 8, OP_BLTU = 9, OP_BGEU = 10;
  localparam int OP_ADDI = 11, OP_SLTI = 12, OP_SLTIU = 13, OP_XORI = 14, OP_ORI = 15;
  localparam int OP_ANDI = 16, OP_SLLI = 17, OP_SRLI = 18, OP_SRAI = 19;
  localparam int OP_ADD = 20, OP_SUB = 21, OP_SLL = 22, OP_SLT = 23, OP_SLTU = 24;
  localparam int OP_XOR = 25, OP_SRL = 26, OP_SRA = 27, OP_OR = 28, OP_AND = 29;
  localparam int IMM_LO = OP_ADDI, IMM_HI = OP_SRAI;
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] vj;
    logic [31:0] vk;
    logic [3:0]  qj;
    logic [3:0]  qk;
    logic [3:0]  dest;
    logic [31:0] pc;
    logic [5:0]  op;
  } rs_entry_t;
  function automatic logic no_tags(int op);
    return op == OP_LUI || op == OP_AUIPC || op == OP_JAL;
  endfunction
  // Ops whose second operand is an immediate never wait on qk
  function automatic logic no_qk(int op);
    return no_tags(op) || op == OP_JALR || (op >= IMM_LO && op <= IMM_HI);
  endfunction
endpackage

// File: rtl/rs_alu_station_if.sv
// rs_alu_station_if: dispatch, CDB snoop and issue signals of the ALU reservation station
interface rs_alu_station_if #(
  parameter int DEPTH  = 16,
  parameter int CDB_CH = 2,
  parameter int ROB_W  = 4,
  parameter int XLEN   = 32,
  parameter int PC_W   = 32,
  parameter int OP_W   = 6
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic                    disp_valid_in;
  logic                    disp_ready_out;
  logic [XLEN-1:0]         disp_a_in;
  logic [XLEN-1:0]         disp_vj_in;
  logic [XLEN-1:0]         disp_vk_in;
  logic [ROB_W-1:0]        disp_qj_in;
  logic [ROB_W-1:0]        disp_qk_in;
  logic [ROB_W-1:0]        disp_dest_in;
  logic [PC_W-1:0]         disp_pc_in;
  logic [OP_W-1:0]         disp_op_in;
  logic [CDB_CH-1:0]       cdb_valid_in;
  logic [CDB_CH*ROB_W-1:0] cdb_tag_in;
  logic [CDB_CH*XLEN-1:0]  cdb_data_in;
  logic                    iss_valid_out;
  logic                    iss_ready_in;
  logic [XLEN-1:0]         iss_a_out;
  logic [XLEN-1:0]         iss_vj_out;
  logic [XLEN-1:0]         iss_vk_out;
  logic [ROB_W-1:0]        iss_dest_out;
  logic [PC_W-1:0]         iss_pc_out;
  logic [OP_W-1:0]         iss_op_out;
  logic [CW-1:0]           occupancy_out;
  modport master (
    output disp_valid_in, disp_a_in, disp_vj_in, disp_vk_in, disp_qj_in, disp_qk_in,
           disp_dest_in, disp_pc_in, disp_op_in, cdb_valid_in, cdb_tag_in, cdb_data_in,
           iss_ready_in,
    input  disp_ready_out, iss_valid_out, iss_a_out, iss_vj_out, iss_vk_out, iss_dest_out,
           iss_pc_out, iss_op_out, occupancy_out
  );
  modport slave (
    input  disp_valid_in, disp_a_in, disp_vj_in, disp_vk_in, disp_qj_in, disp_qk_in,
           disp_dest_in, disp_pc_in, disp_op_in, cdb_valid_in, cdb_tag_in, cdb_data_in,
           iss_ready_in,
    output disp_ready_out, iss_valid_out, iss_a_out, iss_vj_out, iss_vk_out, iss_dest_out,
           iss_pc_out, iss_op_out, occupancy_out
  );
endinterface

// File: rtl/rs_alu_station_age_select.sv
// rs_alu_station_age_select: age matrix tracking entry order and picking the oldest ready entry
module rs_alu_station_age_select #(
  parameter int DEPTH = 16
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     en,
  input  logic                     clr,
  input  logic                     alloc,
  input  logic [$clog2(DEPTH)-1:0] alloc_idx,
  input  logic                     free,
  input  logic [$clog2(DEPTH)-1:0] free_idx,
  input  logic [DEPTH-1:0]         busy,
  input  logic [DEPTH-1:0]         ready,
  output logic [DEPTH-1:0]         grant
);
  localparam int IW = $clog2(DEPTH);
  // older[i][j] set means entry i was allocated before entry j
  logic [DEPTH-1:0] older [DEPTH];
  always_ff @(posedge clk_in) begin
    if (rst_in || (en && clr)) begin
      for (int i = 0; i < DEPTH; i++) older[i] <= '0;
    end else if (en) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (alloc) begin
          older[alloc_idx][j] <= 1'b0;
          older[j][alloc_idx] <= busy[j] && (IW'(j) != alloc_idx);
        end
        if (free) begin
          older[free_idx][j] <= 1'b0;
          older[j][free_idx] <= 1'b0;
        end
      end
    end
  end
  always_comb begin
    grant = ready;
    for (int i = 0; i < DEPTH; i++)
      for (int j = 0; j < DEPTH; j++)
        if (ready[j] && older[j][i]) grant[i] = 1'b0;
  end
endmodule

// File: rtl/rs_alu_station.sv
// rs_alu_station: ALU reservation station holding ops until operands resolve via CDB snoop,
// issuing the oldest ready entry through a registered valid/ready issue stage
module rs_alu_station
  import rs_alu_station_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int CDB_CH = 2,
  parameter int ROB_W  = 4,
  parameter int XLEN   = 32,
  parameter int PC_W   = 32,
  parameter int OP_W   = 6
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic           rdy_in,
  input  logic           flush_in,
  rs_alu_station_if.slave bus
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  typedef struct packed {
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  vj;
    logic [XLEN-1:0]  vk;
    logic [ROB_W-1:0] qj;
    logic [ROB_W-1:0] qk;
    logic [ROB_W-1:0] dest;
    logic [PC_W-1:0]  pc;
    logic [OP_W-1:0]  op;
  } entry_t;
  // Higher channels are visited first so the lowest matching channel is the last to write
  function automatic entry_t snoop(entry_t e, logic [CDB_CH-1:0] v,
                                   logic [CDB_CH*ROB_W-1:0] t, logic [CDB_CH*XLEN-1:0] d);
    entry_t r;
    r = e;
    for (int c = CDB_CH - 1; c >= 0; c--) begin
      if (v[c] && t[c*ROB_W +: ROB_W] != ROB_W'(ROB_NONE) && e.qj == t[c*ROB_W +: ROB_W]) begin
        r.qj = ROB_W'(ROB_NONE);
        r.vj = d[c*XLEN +: XLEN];
      end
      if (v[c] && t[c*ROB_W +: ROB_W] != ROB_W'(ROB_NONE) && e.qk == t[c*ROB_W +: ROB_W]) begin
        r.qk = ROB_W'(ROB_NONE);
        r.vk = d[c*XLEN +: XLEN];
      end
    end
    return r;
  endfunction
  function automatic logic is_ready(entry_t e);
    return no_tags(int'(e.op)) ||
           (e.qj == ROB_W'(ROB_NONE) && (e.qk == ROB_W'(ROB_NONE) || no_qk(int'(e.op))));
  endfunction
  entry_t           ent  [DEPTH];
  entry_t           woke [DEPTH];
  entry_t           disp_ent;
  entry_t           iss;
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] ready;
  logic [DEPTH-1:0] grant;
  logic [CW-1:0]    count;
  logic [IW-1:0]    free_idx;
  logic [IW-1:0]    sel_idx;
  logic             iss_valid;
  logic             disp_fire;
  logic             iss_fire;
  always_comb begin
    disp_ent = snoop(entry_t'{bus.disp_a_in, bus.disp_vj_in, bus.disp_vk_in, bus.disp_qj_in,
                              bus.disp_qk_in, bus.disp_dest_in, bus.disp_pc_in, bus.disp_op_in},
                     bus.cdb_valid_in, bus.cdb_tag_in, bus.cdb_data_in);
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      woke[i]  = snoop(ent[i], bus.cdb_valid_in, bus.cdb_tag_in, bus.cdb_data_in);
      ready[i] = busy[i] && is_ready(ent[i]);
      if (!busy[i]) free_idx = IW'(i);
    end
  end
  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < DEPTH; i++) sel_idx = grant[i] ? IW'(i) : sel_idx;
  end
  assign bus.disp_ready_out = count < CW'(DEPTH);
  assign disp_fire = rdy_in && !flush_in && bus.disp_valid_in && bus.disp_ready_out;
  assign iss_fire  = rdy_in && !flush_in && |ready && (!iss_valid || bus.iss_ready_in);
  rs_alu_station_age_select #(.DEPTH(DEPTH)) u_age (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .en        (rdy_in),
    .clr       (flush_in),
    .alloc     (disp_fire),
    .alloc_idx (free_idx),
    .free      (iss_fire),
    .free_idx  (sel_idx),
    .busy      (busy),
    .ready     (ready),
    .grant     (grant)
  );
  always_ff @(posedge clk_in) begin
    if (rst_in || (rdy_in && flush_in)) begin
      busy      <= '0;
      count     <= '0;
      iss_valid <= 1'b0;
      iss       <= '0;
      iss.op    <= OP_W'(OP_NOP);
    end else if (rdy_in) begin
      for (int i = 0; i < DEPTH; i++) if (busy[i]) ent[i] <= woke[i];
      if (disp_fire) begin
        busy[free_idx] <= 1'b1;
        ent[free_idx]  <= disp_ent;
      end
      if (iss_fire) begin
        busy[sel_idx] <= 1'b0;
        iss           <= ent[sel_idx];
        iss_valid     <= 1'b1;
      end else if (bus.iss_ready_in) begin
        iss_valid <= 1'b0;
        iss.op    <= OP_W'(OP_NOP);
      end
      count <= count + CW'(disp_fire) - CW'(iss_fire);
    end
  end
  assign bus.iss_valid_out = iss_valid;
  assign bus.iss_a_out     = iss.a;
  assign bus.iss_vj_out    = iss.vj;
  assign bus.iss_vk_out    = iss.vk;
  assign bus.iss_dest_out  = iss.dest;
  assign bus.iss_pc_out    = iss.pc;
  assign bus.iss_op_out    = iss.op;
  assign bus.occupancy_out = count;
endmodule

// File: tb/tb_rs_alu_station.sv
// tb_rs_alu_station: directed scenarios plus random traffic against a queue-based station model
module tb_rs_alu_station;
  import rs_alu_station_pkg::*;
  localparam int DEPTH = 16, CDB_CH = 2;
  logic clk = 1'b0, rst = 1'b1, rdy = 1'b1, flush = 1'b0;
  int n_tests = 0, n_fail = 0;
  rs_entry_t mq[$];
  rs_entry_t m_iss;
  bit        m_iv;
  always #5 clk = ~clk;
  rs_alu_station_if #(.DEPTH(DEPTH), .CDB_CH(CDB_CH)) bus();
  rs_alu_station #(.DEPTH(DEPTH), .CDB_CH(CDB_CH)) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .flush_in(flush), .bus(bus)
  );
  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic bit m_ready(rs_entry_t e);
    case (int'(e.op))
      OP_LUI, OP_AUIPC, OP_JAL: return 1'b1;
      OP_JALR, OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI:
        return e.qj == 0;
      default: return e.qj == 0 && e.qk == 0;
    endcase
  endfunction
  function automatic rs_entry_t m_snoop(rs_entry_t e);
    bit dj = 0, dk = 0;
    for (int c = 0; c < CDB_CH; c++) begin
      logic [3:0]  t;
      logic [31:0] d;
      t = bus.cdb_tag_in[c*4 +: 4];
      d = bus.cdb_data_in[c*32 +: 32];
      if (bus.cdb_valid_in[c] && t != 0) begin
        if (!dj && e.qj == t) begin e.vj = d; e.qj = 0; dj = 1; end
        if (!dk && e.qk == t) begin e.vk = d; e.qk = 0; dk = 1; end
      end
    end
    return e;
  endfunction
  task automatic model_edge();
    if (rst || (rdy && flush)) begin
      mq.delete();
      m_iv  = 0;
      m_iss = '0;
    end else if (rdy) begin
      bit full;
      full = mq.size() >= DEPTH;
      if (!m_iv || bus.iss_ready_in) begin
        int k;
        k = -1;
        foreach (mq[i]) if (k < 0 && m_ready(mq[i])) k = i;
        if (k >= 0) begin
          m_iss = mq[k];
          m_iv  = 1;
          mq.delete(k);
        end else begin
          m_iv     = 0;
          m_iss.op = 6'(OP_NOP);
        end
      end
      foreach (mq[i]) mq[i] = m_snoop(mq[i]);
      if (bus.disp_valid_in && !full)
        mq.push_back(m_snoop(rs_entry_t'{bus.disp_a_in, bus.disp_vj_in, bus.disp_vk_in,
                                         bus.disp_qj_in, bus.disp_qk_in, bus.disp_dest_in,
                                         bus.disp_pc_in, bus.disp_op_in}));
    end
  endtask
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check("occ", 160'(bus.occupancy_out), 160'(mq.size()));
    check("disp_ready", 160'(bus.disp_ready_out), 160'(mq.size() < DEPTH));
    check("iss_valid", 160'(bus.iss_valid_out), 160'(m_iv));
    check("iss_op", 160'(bus.iss_op_out), 160'(m_iv ? m_iss.op : 6'(OP_NOP)));
    if (m_iv)
      check("iss_payload",
            160'({bus.iss_a_out, bus.iss_vj_out, bus.iss_vk_out, bus.iss_dest_out, bus.iss_pc_out}),
            160'({m_iss.a, m_iss.vj, m_iss.vk, m_iss.dest, m_iss.pc}));
  endtask
  task automatic idle();
    bus.disp_valid_in = 1'b0;
    bus.cdb_valid_in  = '0;
    flush             = 1'b0;
    rdy               = 1'b1;
  endtask
  task automatic set_disp(input int op, input int qj, input int qk, input logic [31:0] vj,
                          input int dest);
    bus.disp_valid_in = 1'b1;
    bus.disp_op_in    = 6'(op);
    bus.disp_qj_in    = 4'(qj);
    bus.disp_qk_in    = 4'(qk);
    bus.disp_vj_in    = vj;
    bus.disp_vk_in    = $urandom;
    bus.disp_a_in     = $urandom;
    bus.disp_pc_in    = $urandom;
    bus.disp_dest_in  = 4'(dest);
  endtask
  task automatic set_cdb(input int c, input int tag, input logic [31:0] d);
    bus.cdb_valid_in[c]       = 1'b1;
    bus.cdb_tag_in[c*4 +: 4]  = 4'(tag);
    bus.cdb_data_in[c*32 +: 32] = d;
  endtask
  initial begin
    int ops[12];
    ops = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BEQ, OP_BLT, OP_ADDI, OP_SLTI, OP_SRAI,
            OP_ADD, OP_SUB, OP_AND};
    bus.iss_ready_in = 1'b0;
    bus.cdb_tag_in   = '0;
    bus.cdb_data_in  = '0;
    set_disp(OP_ADD, 0, 0, 0, 0);
    idle();
    step();
    step();
    check("rst_occ", 160'(bus.occupancy_out), 160'(0));
    check("rst_ready", 160'(bus.disp_ready_out), 160'(1));
    check("rst_op", 160'(bus.iss_op_out), 160'(OP_NOP));
    rst = 1'b0;
    set_disp(OP_ADD, 0, 0, 32'h11, 1);
    step();
    check("lat_t", 160'(bus.iss_valid_out), 160'(0));
    idle();
    step();
    check("lat_t1", 160'(bus.iss_valid_out), 160'(1));
    check("lat_op", 160'(bus.iss_op_out), 160'(OP_ADD));
    repeat (3) begin
      step();
      check("hold_vj", 160'(bus.iss_vj_out), 160'(32'h11));
    end
    bus.iss_ready_in = 1'b1;
    step();
    check("drain", 160'(bus.iss_valid_out), 160'(0));
    set_disp(OP_ADD, 3, 0, 0, 2);
    step();
    set_disp(OP_ADDI, 0, 7, 0, 3);
    step();
    idle();
    set_cdb(1, 3, 32'h55);
    set_cdb(0, 9, 32'h99);
    step();
    check("wake_first", 160'(bus.iss_op_out), 160'(OP_ADDI));
    idle();
    step();
    check("wake_second", 160'(bus.iss_op_out), 160'(OP_ADD));
    check("wake_vj", 160'(bus.iss_vj_out), 160'(32'h55));
    step();
    set_disp(OP_SUB, 5, 0, 0, 4);
    set_cdb(0, 5, 32'h7);
    step();
    idle();
    step();
    check("bypass_op", 160'(bus.iss_op_out), 160'(OP_SUB));
    check("bypass_vj", 160'(bus.iss_vj_out), 160'(7));
    step();
    set_disp(OP_ADD, 8, 8, 0, 5);
    step();
    idle();
    set_cdb(0, 8, 32'hA);
    set_cdb(1, 8, 32'hB);
    step();
    idle();
    step();
    check("lowch_vj", 160'(bus.iss_vj_out), 160'(32'hA));
    check("lowch_vk", 160'(bus.iss_vk_out), 160'(32'hA));
    step();
    rdy = 1'b0;
    set_disp(OP_LUI, 0, 0, 0, 6);
    step();
    check("rdy_hold", 160'(bus.occupancy_out), 160'(0));
    idle();
    bus.iss_ready_in = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      set_disp(OP_ADD, 1, 0, i, i);
      step();
    end
    check("full_occ", 160'(bus.occupancy_out), 160'(16));
    check("full_ready", 160'(bus.disp_ready_out), 160'(0));
    set_disp(OP_ADD, 2, 0, 0, 15);
    set_cdb(0, 1, 32'hAB);
    step();
    bus.cdb_valid_in = '0;
    step();
    check("free_ready", 160'(bus.disp_ready_out), 160'(1));
    check("free_occ", 160'(bus.occupancy_out), 160'(15));
    step();
    check("refill_occ", 160'(bus.occupancy_out), 160'(16));
    check("refill_ready", 160'(bus.disp_ready_out), 160'(0));
    idle();
    flush = 1'b1;
    step();
    check("flush16_occ", 160'(bus.occupancy_out), 160'(0));
    idle();
    set_disp(OP_LUI, 9, 9, 0, 1);
    step();
    repeat (5) begin
      set_disp(OP_ADD, 4, 0, 0, 2);
      step();
    end
    check("pre_flush_occ", 160'(bus.occupancy_out), 160'(5));
    check("pre_flush_vld", 160'(bus.iss_valid_out), 160'(1));
    idle();
    flush = 1'b1;
    step();
    check("flush_occ", 160'(bus.occupancy_out), 160'(0));
    check("flush_vld", 160'(bus.iss_valid_out), 160'(0));
    check("flush_ready", 160'(bus.disp_ready_out), 160'(1));
    idle();
    bus.iss_ready_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_disp(OP_ADD, i == 2 ? 14 : (i == 9 ? 6 : 15), 0, 0, i);
      step();
    end
    idle();
    set_cdb(0, 14, 32'h1);
    step();
    idle();
    step();
    check("age_slot2", 160'(bus.iss_dest_out), 160'(2));
    step();
    set_disp(OP_ADD, 7, 0, 0, 12);
    step();
    idle();
    set_cdb(0, 7, 32'h2);
    set_cdb(1, 6, 32'h3);
    step();
    idle();
    step();
    check("age_first", 160'(bus.iss_dest_out), 160'(9));
    step();
    check("age_second", 160'(bus.iss_dest_out), 160'(12));
    flush = 1'b1;
    step();
    idle();
    for (int n = 0; n < 3000; n++) begin
      rdy              = ($urandom_range(0, 7) != 0);
      flush            = ($urandom_range(0, 63) == 0);
      bus.iss_ready_in = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 9) < 7)
        set_disp(ops[$urandom_range(0, 11)],
                 $urandom_range(0, 1) ? 0 : $urandom_range(1, 15),
                 $urandom_range(0, 1) ? 0 : $urandom_range(1, 15),
                 $urandom, $urandom_range(0, 15));
      else
        bus.disp_valid_in = 1'b0;
      bus.cdb_valid_in = 2'($urandom);
      bus.cdb_tag_in   = 8'($urandom);
      bus.cdb_data_in  = {$urandom, $urandom};
      step();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
